simon_playback_seq: RTL and testbench

Round-playback sequencer for the Simon game. On a start request it reads entries 0..length-1 from the sequence memory one at a time and shows each on the four LEDs as a timed on/off flash, with a dark lead-in before the first entry. It then pulses done. It sits between the game FSM, which issues start and length, and the sequence memory read port and LED outputs. It relieves the FSM of read-address sequencing, read-latency alignment and flash timing.

---
 rtl/simon_playback_seq_if.sv | 21 ++
 rtl/simon_playback_seq.sv | 158 +++++++++++++++
 tb/tb_simon_playback_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/simon_playback_seq_if.sv
// Read port between the playback sequencer and the sequence memory.
// seq_val is valid the cycle after rd_en (registered memory).
interface simon_playback_seq_if #(
    parameter int ADDR_W = 4
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        seq_val;

    modport master (
        output rd_en,
        output rd_addr,
        input  seq_val
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output seq_val
    );
endinterface

// File: rtl/simon_playback_seq.sv
// Simon round playback: lead-in, then fetch/capture/show/dark per entry.
// All outputs decode from registered state; counters count down to 1.
module simon_playback_seq #(
    parameter int ADDR_W    = 4,
    parameter int CNT_W     = 8,
    parameter int GAP_TICKS = 8,
    parameter int ON_TICKS  = 8,
    parameter int OFF_TICKS = 4
) (
    input  logic                clk_tick,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   length,
    input  logic                abort,
    simon_playback_seq_if.master mem,
    output logic [3:0]          led,
    output logic                busy,
    output logic                done,
    output logic [2:0]          state,
    output logic [ADDR_W-1:0]   step_idx
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_FETCH = 3'd2,
        S_CAPT  = 3'd3,
        S_SHOW  = 3'd4,
        S_DARK  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    // A tick count of 2^CNT_W truncates to 0, which still yields
    // 2^CNT_W cycles because the counter wraps down to 1.
    localparam logic [CNT_W-1:0] L_GAP = CNT_W'(GAP_TICKS);
    localparam logic [CNT_W-1:0] L_ON  = CNT_W'(ON_TICKS);
    localparam logic [CNT_W-1:0] L_OFF = CNT_W'(OFF_TICKS);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_step;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_val;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] w_len_nxt;
    logic [ADDR_W-1:0] w_step_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [1:0]        w_val_nxt;
    logic              w_cnt_last;
    logic              w_last_step;

    assign w_cnt_last  = (r_cnt == CNT_W'(1));
    assign w_last_step = (r_step == r_len - ADDR_W'(1));

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_tick) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_step  <= '0;
            r_addr  <= '0;
            r_val   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_step  <= w_step_nxt;
            r_addr  <= w_addr_nxt;
            r_val   <= w_val_nxt;
        end
    end

    // Next-state and datapath updates; abort overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_step_nxt  = r_step;
        w_addr_nxt  = r_addr;
        w_val_nxt   = r_val;

        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        w_len_nxt  = length;
                        w_step_nxt = '0;
                        if (length == '0) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_LEAD;
                            w_cnt_nxt   = L_GAP;
                        end
                    end
                end
                S_LEAD: begin
                    if (w_cnt_last) begin
                        w_state_nxt = S_FETCH;
                        w_addr_nxt  = r_step;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                S_FETCH: begin
                    w_state_nxt = S_CAPT;
                end
                S_CAPT: begin
                    w_val_nxt   = mem.seq_val;
                    w_cnt_nxt   = L_ON;
                    w_state_nxt = S_SHOW;
                end
                S_SHOW: begin
                    if (w_cnt_last) begin
                        w_cnt_nxt   = L_OFF;
                        w_state_nxt = S_DARK;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                S_DARK: begin
                    if (!w_cnt_last) begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end else if (w_last_step) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_step_nxt  = r_step + ADDR_W'(1);
                        w_addr_nxt  = r_step + ADDR_W'(1);
                        w_state_nxt = S_FETCH;
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        mem.rd_en   = (r_state == S_FETCH);
        mem.rd_addr = r_addr;
        led         = (r_state == S_SHOW) ? (4'b0001 << r_val) : 4'b0000;
        busy        = (r_state != S_IDLE);
        done        = (r_state == S_DONE);
        state       = r_state;
        step_idx    = r_step;
    end

endmodule

// File: tb/tb_simon_playback_seq.sv
// Directed bench for simon_playback_seq with a registered memory model.
// Cycle numbering: start is sampled at edge 0, cycle 1 follows it.
module tb_simon_playback_seq;

    logic       clk_tick = 1'b0;
    logic       reset_n;
    logic       start;
    logic [3:0] length;
    logic       abort;
    logic [3:0] led;
    logic       busy;
    logic       done;
    logic [2:0] state;
    logic [3:0] step_idx;

    int errors = 0;
    int checks = 0;
    int nrd;
    bit got_done;

    logic [1:0] mem_arr [0:15];

    simon_playback_seq_if #(.ADDR_W(4)) m ();

    simon_playback_seq dut (
        .clk_tick (clk_tick),
        .reset_n  (reset_n),
        .start    (start),
        .length   (length),
        .abort    (abort),
        .mem      (m.master),
        .led      (led),
        .busy     (busy),
        .done     (done),
        .state    (state),
        .step_idx (step_idx)
    );

    always #5 clk_tick = ~clk_tick;

    // Registered sequence memory: data one cycle after rd_en.
    always @(posedge clk_tick) begin
        if (m.rd_en) m.seq_val <= mem_arr[m.rd_addr];
    end

    task automatic tick();
        @(posedge clk_tick);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_arr[i] = 2'd1;
        mem_arr[0] = 2'd2;
        mem_arr[1] = 2'd0;
        mem_arr[2] = 2'd3;

        reset_n = 1'b0;
        start   = 1'b0;
        length  = 4'd0;
        abort   = 1'b0;
        repeat (2) tick();
        chk("rst_state", state, 0);
        chk("rst_rden", m.rd_en, 0);
        chk("rst_addr", m.rd_addr, 0);
        chk("rst_led", led, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_step", step_idx, 0);
        reset_n = 1'b1;
        tick();

        // Pass 0: plain length-3 run. Pass 1: re-start at cycle 20
        // and length changed to 5 mid-run; timing must be identical.
        for (int s = 0; s < 2; s++) begin
            length = 4'd3;
            start  = 1'b1;
            tick();
            start = 1'b0;
            nrd   = 0;
            for (int c = 1; c <= 52; c++) begin
                logic       e_rd;
                logic [3:0] e_led;
                e_rd = (c == 9) || (c == 23) || (c == 37);
                if (c >= 11 && c <= 18)      e_led = 4'b0100;
                else if (c >= 25 && c <= 32) e_led = 4'b0001;
                else if (c >= 39 && c <= 46) e_led = 4'b1000;
                else                          e_led = 4'b0000;
                if (m.rd_en) nrd++;
                if (c <= 8) chk($sformatf("lead@%0d", c), state, 1);
                chk($sformatf("rden@%0d", c), m.rd_en, e_rd);
                if (e_rd)
                    chk($sformatf("addr@%0d", c), m.rd_addr, (c - 9) / 14);
                chk($sformatf("led@%0d", c), led, e_led);
                chk($sformatf("done@%0d", c), done, (c == 51));
                chk($sformatf("busy@%0d", c), busy, (c <= 51));
                start = (s == 1) && (c == 20);
                if (s == 1 && c == 5) length = 4'd5;
                if (c < 52) tick();
            end
            chk("reads", nrd, 3);
            chk("idle_after", state, 0);
            start  = 1'b0;
            length = 4'd0;
            tick();
        end

        // Zero-length round.
        length = 4'd0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk("z_busy", busy, 1);
        chk("z_done", done, 1);
        chk("z_rden", m.rd_en, 0);
        chk("z_led", led, 0);
        tick();
        chk("z_state2", state, 0);
        chk("z_busy2", busy, 0);
        chk("z_done2", done, 0);
        tick();

        // Abort during SHOW of entry 0, then restart.
        length = 4'd3;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (13) tick();
        chk("ab_led14", led, 4'b0100);
        chk("ab_state14", state, 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_state15", state, 0);
        chk("ab_led15", led, 0);
        chk("ab_done15", done, 0);
        chk("ab_busy15", busy, 0);
        tick();
        chk("ab_done16", done, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ab_lead", state, 1);
        repeat (8) tick();
        chk("ab_rden", m.rd_en, 1);
        chk("ab_addr", m.rd_addr, 0);
        got_done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            tick();
        end
        chk("ab_replay_done", got_done, 1);
        tick();
        chk("ab_idle", state, 0);

        // Abort together with start in IDLE.
        abort  = 1'b1;
        start  = 1'b1;
        length = 4'd2;
        tick();
        chk("as_state", state, 0);
        chk("as_busy", busy, 0);
        abort = 1'b0;
        start = 1'b0;
        tick();
        chk("as_state2", state, 0);

        // Reset mid-run, at cycle 12 and at cycle 26 (entry 1 shown).
        for (int k = 0; k < 2; k++) begin
            int rc;
            rc     = (k == 0) ? 12 : 26;
            length = 4'd3;
            start  = 1'b1;
            tick();
            start = 1'b0;
            repeat (rc - 1) tick();
            if (k == 1) begin
                chk("mr_led26", led, 4'b0001);
                chk("mr_step26", step_idx, 1);
            end
            reset_n = 1'b0;
            tick();
            reset_n = 1'b1;
            chk($sformatf("mr_state_%0d", rc), state, 0);
            chk($sformatf("mr_rden_%0d", rc), m.rd_en, 0);
            chk($sformatf("mr_addr_%0d", rc), m.rd_addr, 0);
            chk($sformatf("mr_led_%0d", rc), led, 0);
            chk($sformatf("mr_busy_%0d", rc), busy, 0);
            chk($sformatf("mr_done_%0d", rc), done, 0);
            chk($sformatf("mr_step_%0d", rc), step_idx, 0);
            repeat (3) tick();
            chk($sformatf("mr_hold_%0d", rc), state, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
